extfreq_master: RTL and testbench



---
 rtl/extfreq_master.sv | 222 ++++++++++++++++++++++
 tb/tb_extfreq_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extfreq_master.sv
// ---------------------------------------------------------------------------
// extfreq_master
//
// Master-side timing source for the external-frequency link. The local
// 125 MHz clock is divided by DIV to produce the shared link frequency that
// slave boards multiply back up. Counter-reset and inhibit commands travel
// as short serial frames on a companion command line, one bit per freqout
// period. A local CNT_W-bit counter mirrors the count the slaves hold.
//
// Frame on cmd (MSB first, each bit held one freqout period):
//   start=1, op[1:0], [parity], stop=0
//   op 01 = reset counter, 10 = inhibit on, 11 = inhibit off
//
// Optional feature (macro EXTFREQ_CMD_PARITY_EN):
//   defined   -> odd parity bit over op inserted before stop (5-bit frame)
//   undefined -> no parity bit (4-bit frame), all other timing unchanged
//
// Parameters:
//   DIV    clock divide ratio for freqout (even, >= 4)
//   CNT_W  width of the mirrored counter
//
// Ports:
//   clk            in   125 MHz system clock
//   reset_n        in   asynchronous, active-low reset
//   enable         in   link enable; 0 stops freqout and command traffic
//   cnt_reset_req  in   one-clk pulse requesting a counter reset everywhere
//   inhibit        in   level; requested counter-inhibit state
//   freqout        out  link frequency, clk/DIV, 50% duty
//   cmd            out  serial command line, idle 0
//   busy           out  request pending or frame in flight
//   counter        out  local counter mirroring the slave counters
// ---------------------------------------------------------------------------
module extfreq_master #(
  parameter int DIV   = 8,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cnt_reset_req,
  input  logic             inhibit,
  output logic             freqout,
  output logic             cmd,
  output logic             busy,
  output logic [CNT_W-1:0] counter
);

  localparam int PH_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV / 2);

`ifdef EXTFREQ_CMD_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] OP_RST     = 2'b01;
  localparam logic [1:0] OP_INH_ON  = 2'b10;
  localparam logic [1:0] OP_INH_OFF = 2'b11;

  logic [PH_W-1:0]      r_phase;
  logic [1:0]           r_state;
  logic [1:0]           r_op;
  logic [IDX_W-1:0]     r_bitIdx;
  logic [FRAME_LEN-1:0] r_shift;
  logic                 r_pendRst;
  logic                 r_lastSentInh;
  logic                 r_appliedInh;
  logic [CNT_W-1:0]     r_counter;

  logic                 w_boundary;
  logic                 w_inhPending;
  logic                 w_reqPending;
  logic [1:0]           w_newOp;
  logic                 w_completing;
  logic                 w_completeRst;
  logic                 w_completeInh;

  // Full frame image for a given op, start bit in the MSB so the frame can
  // be shifted out left; parity makes the count of ones over op odd.
  function automatic logic [FRAME_LEN-1:0] frameBits(input logic [1:0] op);
`ifdef EXTFREQ_CMD_PARITY_EN
    return {1'b1, op, ~(op[1] ^ op[0]), 1'b0};
`else
    return {1'b1, op, 1'b0};
`endif
  endfunction

  // A boundary is the cycle where freqout rises; every cmd change and every
  // frame decision happens on the clock edge that ends such a cycle.
  assign w_boundary = enable & (r_phase == '0);

  // The inhibit request is judged against what the slaves were last told,
  // so a level that toggles away and back before a frame starts is silent.
  assign w_inhPending = inhibit ^ r_lastSentInh;
  assign w_reqPending = r_pendRst | w_inhPending;

  // Counter reset outranks inhibit; the inhibit frame follows after the gap.
  assign w_newOp = r_pendRst ? OP_RST : (inhibit ? OP_INH_ON : OP_INH_OFF);

  // The boundary ending the stop bit is where the frame takes effect.
  assign w_completing  = w_boundary & (r_state == ST_SEND) & (r_bitIdx == IDX_LAST);
  assign w_completeRst = w_completing & (r_op == OP_RST);
  assign w_completeInh = w_completing & r_op[1];

  // Phase counter for the divider; parked at zero while the link is off so
  // the first enabled cycle is immediately a boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '0;
    end else if (!enable) begin
      r_phase <= '0;
    end else if (r_phase == PH_LAST) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Frame sequencer. Dropping enable aborts whatever is on the line without
  // applying it; pending requests survive and restart from the start bit.
  // The gap-ending boundary also serves as the next frame's start boundary,
  // so back-to-back frames are separated by exactly one idle period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else if (!enable) begin
      r_state  <= ST_IDLE;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else if (w_boundary) begin
      case (r_state)
        ST_IDLE: begin
          if (w_reqPending) begin
            r_state  <= ST_SEND;
            r_op     <= w_newOp;
            r_shift  <= frameBits(w_newOp);
            r_bitIdx <= '0;
          end
        end
        ST_SEND: begin
          if (r_bitIdx == IDX_LAST) begin
            r_state <= ST_GAP;
            r_shift <= '0;
          end else begin
            r_shift  <= {r_shift[FRAME_LEN-2:0], 1'b0};
            r_bitIdx <= r_bitIdx + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_reqPending) begin
            r_state  <= ST_SEND;
            r_op     <= w_newOp;
            r_shift  <= frameBits(w_newOp);
            r_bitIdx <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pending counter reset. Extra pulses before completion merge into the
  // one frame; a pulse landing on the completion edge itself is kept as a
  // fresh request rather than being swallowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pendRst <= 1'b0;
    end else if (cnt_reset_req) begin
      r_pendRst <= 1'b1;
    end else if (w_completeRst) begin
      r_pendRst <= 1'b0;
    end
  end

  // Applied and last-sent inhibit move together, only when an inhibit frame
  // completes; op 10 turns inhibit on, op 11 turns it off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lastSentInh <= 1'b0;
      r_appliedInh  <= 1'b0;
    end else if (w_completeInh) begin
      r_lastSentInh <= ~r_op[0];
      r_appliedInh  <= ~r_op[0];
    end
  end

  // Mirrored counter. The clear from a completed reset frame wins over the
  // increment so master and slaves restart from the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= '0;
    end else if (w_completeRst) begin
      r_counter <= '0;
    end else if (enable && !r_appliedInh) begin
      r_counter <= r_counter + 1'b1;
    end
  end

  // Outputs are gated so the link goes quiet the moment enable or reset
  // drops, without waiting for a clock edge.
  assign freqout = reset_n & enable & (r_phase < PH_HALF);
  assign cmd     = enable & (r_state == ST_SEND) & r_shift[FRAME_LEN-1];
  assign busy    = reset_n & (r_pendRst | w_inhPending | (r_state != ST_IDLE));
  assign counter = r_counter;

endmodule

// File: tb/tb_extfreq_master.sv
// ---------------------------------------------------------------------------
// tb_extfreq_master
//
// Directed bench for extfreq_master with DIV=8. Expected cmd frames are
// queued when a request is driven and popped bit by bit as the line is
// sampled. A small reference of the divider phase and the mirrored counter
// is stepped on every clock. A second instance with CNT_W=4 covers wrap.
// ---------------------------------------------------------------------------
module tb_extfreq_master;

  localparam int DIV  = 8;
  localparam int HALF = DIV / 2;
`ifdef EXTFREQ_CMD_PARITY_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        cntResetReq;
  logic        inhibit;
  logic        freqout;
  logic        cmd;
  logic        busy;
  logic [21:0] counter;

  logic        wrapEnable;
  logic        wrapFreqout;
  logic        wrapCmd;
  logic        wrapBusy;
  logic [3:0]  wrapCounter;

  int          errors = 0;
  int          checks = 0;
  int          phaseModel = 0;
  logic [21:0] cntModel = '0;
  logic        inhModel = 1'b0;
  logic [1:0]  completeOp = 2'b00;
  logic        expQ[$];

  extfreq_master #(.DIV(DIV), .CNT_W(22)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .cnt_reset_req(cntResetReq), .inhibit(inhibit),
    .freqout(freqout), .cmd(cmd), .busy(busy), .counter(counter)
  );

  extfreq_master #(.DIV(DIV), .CNT_W(4)) dutWrap (
    .clk(clk), .reset_n(reset_n), .enable(wrapEnable),
    .cnt_reset_req(1'b0), .inhibit(1'b0),
    .freqout(wrapFreqout), .cmd(wrapCmd), .busy(wrapBusy), .counter(wrapCounter)
  );

  // 125 MHz-style free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever mis-sized
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One clock: step the reference at the edge, sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      phaseModel = 0;
      cntModel   = '0;
      inhModel   = 1'b0;
    end else begin
      phaseModel = enable ? (phaseModel + 1) % DIV : 0;
      if (completeOp == 2'b01) cntModel = '0;
      else if (enable && !inhModel) cntModel = cntModel + 1'b1;
      if (completeOp[1]) inhModel = ~completeOp[0];
    end
    completeOp = 2'b00;
    #1;
    checkOutput("freqout", freqout, reset_n && enable && (phaseModel < HALF));
    checkOutput("counter", counter, cntModel);
  endtask

  task automatic applyStimulus(input logic en, input logic req, input logic inh);
    enable      = en;
    cntResetReq = req;
    inhibit     = inh;
    tick();
  endtask

  task automatic pushFrame(input logic [1:0] op);
    logic [4:0] bits;
    case (op)
`ifdef EXTFREQ_CMD_PARITY_EN
      2'b01:   bits = 5'b10100;
      2'b10:   bits = 5'b11000;
      default: bits = 5'b11110;
`else
      2'b01:   bits = 5'b01010;
      2'b10:   bits = 5'b01100;
      default: bits = 5'b01110;
`endif
    endcase
    for (int i = FRAME_LEN - 1; i >= 0; i--) expQ.push_back(bits[i]);
  endtask

  task automatic waitFrameStart(input string tag);
    int n;
    n = 0;
    while (cmd !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checkOutput({tag, "_start"}, cmd, 1);
    checkOutput({tag, "_startPhase"}, phaseModel, 1);
  endtask

  // Pop one frame from the scoreboard and check every clock of it; the
  // last tick is the completion edge. Optional glitch stimulus is driven
  // mid-frame.
  task automatic receiveFrame(input string tag, input logic [1:0] op, input bit glitch);
    logic e;
    int idx;
    idx = 0;
    for (int b = 0; b < FRAME_LEN; b++) begin
      e = expQ.pop_front();
      for (int j = 0; j < DIV; j++) begin
        checkOutput($sformatf("%s_bit%0d", tag, b), cmd, e);
        checkOutput({tag, "_busy"}, busy, 1);
        if (glitch) begin
          case (idx)
            3, 6:       inhibit = ~inhibit;
            9, 13, 17:  cntResetReq = 1'b1;
            10, 14, 18: cntResetReq = 1'b0;
            default: ;
          endcase
        end
        if (b == FRAME_LEN - 1 && j == DIV - 1) completeOp = op;
        tick();
        idx++;
      end
    end
  endtask

  task automatic checkGap(input string tag, input logic busyAfter);
    for (int j = 0; j < DIV; j++) begin
      checkOutput({tag, "_cmd"}, cmd, 0);
      checkOutput({tag, "_busy"}, busy, 1);
      tick();
    end
    checkOutput({tag, "_busyAfter"}, busy, busyAfter);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    cntResetReq = 1'b0;
    inhibit     = 1'b0;
    wrapEnable  = 1'b0;
    repeat (3) tick();

    // reset values, even with the link enabled
    enable = 1'b1;
    tick();
    checkOutput("rstFreqout", freqout, 0);
    checkOutput("rstCmd", cmd, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstCounter", counter, 0);
    checkOutput("rstWrapCounter", wrapCounter, 0);

    // divider and free-running counter
    $display("[TB] divider");
    reset_n = 1'b1;
    #1;
    checkOutput("firstBoundary", freqout, 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput("counterRun", counter, k);
      checkOutput("cmdIdle", cmd, 0);
    end

    // enable low holds counter and silences freqout
    enable = 1'b0;
    #1;
    checkOutput("offFreqout", freqout, 0);
    repeat (5) tick();
    checkOutput("offCounterHold", counter, 16);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("onCounterResume", counter, 17);
    repeat (3) tick();

    // single reset frame
    $display("[TB] reset frame");
    applyStimulus(1'b1, 1'b1, 1'b0);
    cntResetReq = 1'b0;
    checkOutput("reqBusy", busy, 1);
    pushFrame(2'b01);
    waitFrameStart("rst");
    receiveFrame("rst", 2'b01, 1'b0);
    checkOutput("rstCleared", counter, 0);
    checkGap("rstGap", 1'b0);
    repeat (4) tick();

    // reset and inhibit-on requested together
    $display("[TB] simultaneous requests");
    applyStimulus(1'b1, 1'b1, 1'b1);
    cntResetReq = 1'b0;
    pushFrame(2'b01);
    pushFrame(2'b10);
    waitFrameStart("sim");
    receiveFrame("simRst", 2'b01, 1'b0);
    checkGap("simGap", 1'b1);
    checkOutput("simGapLen", cmd, 1);
    receiveFrame("simInh", 2'b10, 1'b0);
    checkGap("inhGap", 1'b0);
    repeat (6) tick();

    // inhibit glitch and merged reset pulses during a reset frame
    $display("[TB] glitch and merge");
    applyStimulus(1'b1, 1'b1, 1'b1);
    cntResetReq = 1'b0;
    pushFrame(2'b01);
    waitFrameStart("glitch");
    receiveFrame("glitch", 2'b01, 1'b1);
    checkOutput("glitchCleared", counter, 0);
    checkGap("glitchGap", 1'b0);
    for (int k = 0; k < 3 * DIV; k++) begin
      checkOutput("noExtraFrame", cmd, 0);
      checkOutput("noExtraBusy", busy, 0);
      tick();
    end

    // abort an inhibit-off frame, then resend
    $display("[TB] abort");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFrameStart("abort");
    for (int k = 0; k < 12; k++) begin
      checkOutput("abortEarlyBits", cmd, 1);
      tick();
    end
    enable = 1'b0;
    #1;
    checkOutput("abortCmd", cmd, 0);
    checkOutput("abortFreqout", freqout, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("abortHoldCmd", cmd, 0);
      checkOutput("abortPending", busy, 1);
    end
    enable = 1'b1;
    pushFrame(2'b11);
    waitFrameStart("resend");
    receiveFrame("resend", 2'b11, 1'b0);
    checkGap("offGap", 1'b0);
    repeat (4) tick();

    // reset asserted in the middle of a frame
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 1'b1, 1'b0);
    cntResetReq = 1'b0;
    waitFrameStart("midRst");
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    checkOutput("midRstCmd", cmd, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstCounter", counter, 0);
    checkOutput("midRstFreqout", freqout, 0);
    tick();
    reset_n = 1'b1;
    repeat (DIV * 2) begin
      tick();
      checkOutput("midRstQuiet", cmd, 0);
    end

    // 4-bit counter wrap
    $display("[TB] wrap");
    checkOutput("wrapIdle", wrapCounter, 0);
    wrapEnable = 1'b1;
    repeat (15) tick();
    checkOutput("wrapTop", wrapCounter, 15);
    checkOutput("wrapCmd", wrapCmd, 0);
    checkOutput("wrapBusy", wrapBusy, 0);
    tick();
    checkOutput("wrapZero", wrapCounter, 0);
    checkOutput("wrapFreqout", wrapFreqout, (phaseModel < HALF) ? 1 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
